// File: rtl/athos_ip_pkg.sv
// Shared ATHOS IP definitions: operation codes and dispatcher FSM states.
package athos_ip_pkg;

  // Operation codes carried on the 6-bit op fields.
  typedef enum logic [5:0] {
    OP_NULL   = 6'h00,
    OP_KECCAK = 6'h01,
    OP_NTT    = 6'h02,
    OP_INTT   = 6'h03,
    OP_TRNG   = 6'h04
  } op_e;

  // Command dispatcher FSM states.
  typedef enum logic [1:0] {
    D_IDLE  = 2'd0,
    D_ISSUE = 2'd1,
    D_WAIT  = 2'd2
  } disp_state_e;

  // True for the ops the control unit can execute; NULL and unassigned codes are rejected.
  function automatic logic is_legal_op(input logic [5:0] op);
    logic legal;
    case (op)
      OP_KECCAK, OP_NTT, OP_INTT, OP_TRNG: legal = 1'b1;
      default:                             legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/athos_cmd_fifo.sv
// Synchronous FIFO with combinational head read, occupancy count and full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module athos_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             push;
  logic             pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Requests are gated here so a misbehaving caller cannot corrupt the pointers.
  assign push = wr_en_i & ~full_o;
  assign pop  = rd_en_i & ~empty_o;

  // Occupancy next state; push and pop together cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/athos_cmd_dispatcher.sv
// Command dispatcher: queues legal commands and issues them one at a time to the
// control unit, tracking completions with a sticky interrupt and a wrapping counter.
module athos_cmd_dispatcher
  import athos_ip_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            cmd_valid_i,
  output logic                            cmd_ready_o,
  input  logic [5:0]                      cmd_op_i,
  input  logic [ADDR_W-1:0]               cmd_src_i,
  input  logic [ADDR_W-1:0]               cmd_dst_i,
  input  logic [LEN_W-1:0]                cmd_len_i,
  output logic                            cu_start_o,
  output logic [5:0]                      cu_op_o,
  output logic [ADDR_W-1:0]               cu_src_o,
  output logic [ADDR_W-1:0]               cu_dst_o,
  output logic [LEN_W-1:0]                cu_len_o,
  input  logic                            cu_done_i,
  output logic                            irq_o,
  input  logic                            irq_clr_i,
  output logic                            err_o,
  input  logic                            err_clr_i,
  output logic                            busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] pending_o,
  output logic [7:0]                      done_cnt_o
);

  localparam int ENTRY_W = 6 + 2*ADDR_W + LEN_W;

  disp_state_e         state_q;
  logic                start_q;
  logic [5:0]          op_q;
  logic [ADDR_W-1:0]   src_q;
  logic [ADDR_W-1:0]   dst_q;
  logic [LEN_W-1:0]    len_q;
  logic                irq_q;
  logic                irq_d;
  logic                err_q;
  logic                err_d;
  logic [7:0]          done_cnt_q;

  logic                fifo_full;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  head;
  logic [5:0]          head_op;
  logic [ADDR_W-1:0]   head_src;
  logic [ADDR_W-1:0]   head_dst;
  logic [LEN_W-1:0]    head_len;
  logic                accept;
  logic                push;
  logic                illegal;
  logic                pop;
  logic                done_take;

  assign cmd_ready_o = ~fifo_full;
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign push        = accept & is_legal_op(cmd_op_i);
  assign illegal     = accept & ~is_legal_op(cmd_op_i);
  assign pop         = (state_q == D_IDLE) & ~fifo_empty;
  assign done_take   = (state_q == D_WAIT) & cu_done_i;

  assign {head_op, head_src, head_dst, head_len} = head;

  athos_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .wr_en_i   (push),
    .wr_data_i ({cmd_op_i, cmd_src_i, cmd_dst_i, cmd_len_i}),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (pending_o)
  );

  // Issue FSM: latch the head entry, pulse start for one cycle, then wait for done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= D_IDLE;
      start_q <= 1'b0;
      op_q    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        D_IDLE: begin
          if (pop) begin
            op_q    <= head_op;
            src_q   <= head_src;
            dst_q   <= head_dst;
            len_q   <= head_len;
            start_q <= 1'b1;
            state_q <= D_ISSUE;
          end
        end
        D_ISSUE: state_q <= D_WAIT;
        D_WAIT:  if (cu_done_i) state_q <= D_IDLE;
        default: state_q <= D_IDLE;
      endcase
    end
  end

  // Sticky flags: a set in the same cycle as a clear takes priority.
  assign irq_d = done_take | (irq_q & ~irq_clr_i);
  assign err_d = illegal   | (err_q & ~err_clr_i);

  // Status registers: interrupt, error flag and completion counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q      <= 1'b0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      irq_q <= irq_d;
      err_q <= err_d;
      if (done_take) done_cnt_q <= done_cnt_q + 8'd1;
    end
  end

  assign cu_start_o = start_q;
  assign cu_op_o    = op_q;
  assign cu_src_o   = src_q;
  assign cu_dst_o   = dst_q;
  assign cu_len_o   = len_q;
  assign irq_o      = irq_q;
  assign err_o      = err_q;
  assign done_cnt_o = done_cnt_q;
  assign busy_o     = (state_q != D_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_athos_cmd_dispatcher.sv
// Directed bench for the command dispatcher with hand-computed expectations.
module tb_athos_cmd_dispatcher;
  import athos_ip_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [5:0]  cmd_op_i;
  logic [31:0] cmd_src_i;
  logic [31:0] cmd_dst_i;
  logic [15:0] cmd_len_i;
  logic        cu_start_o;
  logic [5:0]  cu_op_o;
  logic [31:0] cu_src_o;
  logic [31:0] cu_dst_o;
  logic [15:0] cu_len_o;
  logic        cu_done_i;
  logic        irq_o;
  logic        irq_clr_i;
  logic        err_o;
  logic        err_clr_i;
  logic        busy_o;
  logic [2:0]  pending_o;
  logic [7:0]  done_cnt_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int start_cnt = 0;

  athos_cmd_dispatcher #(
    .FIFO_DEPTH (4),
    .ADDR_W     (32),
    .LEN_W      (16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_src_i   (cmd_src_i),
    .cmd_dst_i   (cmd_dst_i),
    .cmd_len_i   (cmd_len_i),
    .cu_start_o  (cu_start_o),
    .cu_op_o     (cu_op_o),
    .cu_src_o    (cu_src_o),
    .cu_dst_o    (cu_dst_o),
    .cu_len_o    (cu_len_o),
    .cu_done_i   (cu_done_i),
    .irq_o       (irq_o),
    .irq_clr_i   (irq_clr_i),
    .err_o       (err_o),
    .err_clr_i   (err_clr_i),
    .busy_o      (busy_o),
    .pending_o   (pending_o),
    .done_cnt_o  (done_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycle index and a tally of start pulses seen at each rising edge.
  always @(posedge clk_i) begin
    cyc = cyc + 1;
    if (cu_start_o) start_cnt = start_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("cyc=%0d check %s observed=%0h expected=%0h", cyc, tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [5:0] ops [4];
    int s0;
    int timeouts;
    int op_mism;
    logic found;

    ops[0] = OP_KECCAK; ops[1] = OP_NTT; ops[2] = OP_INTT; ops[3] = OP_TRNG;
    rst_ni = 1'b0; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_src_i = '0;
    cmd_dst_i = '0; cmd_len_i = '0; cu_done_i = 1'b0; irq_clr_i = 1'b0; err_clr_i = 1'b0;

    // Reset state
    step(); step();
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_start", cu_start_o, 0);
    chk("rst_op", cu_op_o, 0);
    chk("rst_src", cu_src_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_pending", pending_o, 0);
    chk("rst_irq_err_cnt", {irq_o, err_o, done_cnt_o}, 0);
    rst_ni = 1'b1;

    // Single NTT command accepted at cycle 10
    while (cyc < 10) step();
    cmd_valid_i = 1'b1; cmd_op_i = OP_NTT; cmd_src_i = 32'h100; cmd_dst_i = 32'h200; cmd_len_i = 16'd256;
    chk("t1_ready", cmd_ready_o, 1);
    step();
    cmd_valid_i = 1'b0;
    chk("t1_n1_start", cu_start_o, 0);
    chk("t1_n1_pending", pending_o, 1);
    step();
    chk("t1_cyc12", cyc, 12);
    chk("t1_start", cu_start_o, 1);
    chk("t1_op", cu_op_o, OP_NTT);
    chk("t1_src", cu_src_o, 32'h100);
    chk("t1_dst", cu_dst_o, 32'h200);
    chk("t1_len", cu_len_o, 256);
    chk("t1_pending0", pending_o, 0);
    step();
    chk("t1_start_pulse", cu_start_o, 0);
    chk("t1_busy", busy_o, 1);
    while (cyc < 39) step();
    chk("t1_hold_fields", {cu_op_o, cu_src_o[11:0], cu_len_o}, {6'h02, 12'h100, 16'd256});
    step();
    cu_done_i = 1'b1;
    step();
    cu_done_i = 1'b0;
    chk("t1_irq", irq_o, 1);
    chk("t1_done_cnt", done_cnt_o, 1);
    chk("t1_idle", busy_o, 0);

    // Done while idle is ignored
    s0 = start_cnt;
    cu_done_i = 1'b1;
    step();
    cu_done_i = 1'b0;
    step();
    chk("idle_done_cnt", done_cnt_o, 1);
    chk("idle_done_nostart", start_cnt - s0, 0);
    irq_clr_i = 1'b1;
    step();
    irq_clr_i = 1'b0;
    chk("irq_clear", irq_o, 0);

    // Illegal ops: NULL then 0x3F
    cmd_valid_i = 1'b1; cmd_op_i = OP_NULL;
    step();
    cmd_valid_i = 1'b0;
    chk("null_err", err_o, 1);
    chk("null_notq", {busy_o, pending_o}, 0);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("err_clear", err_o, 0);
    cmd_valid_i = 1'b1; cmd_op_i = 6'h3F;
    step();
    cmd_valid_i = 1'b0;
    chk("op3f_err", err_o, 1);
    chk("op3f_notq", {busy_o, pending_o}, 0);
    cmd_valid_i = 1'b1; cmd_op_i = 6'h3F; err_clr_i = 1'b1;
    step();
    cmd_valid_i = 1'b0; err_clr_i = 1'b0;
    chk("err_set_wins", err_o, 1);
    err_clr_i = 1'b1;
    step();
    err_clr_i = 1'b0;
    chk("err_clear2", err_o, 0);
    step(); step();
    chk("illegal_nostart", start_cnt - s0, 0);

    // Five back-to-back commands, control unit stalled
    s0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      cmd_valid_i = 1'b1; cmd_op_i = ops[i % 4];
      cmd_src_i = 32'(i * 16); cmd_dst_i = 32'(i); cmd_len_i = 16'(i + 1);
      chk($sformatf("b2b_ready%0d", i), cmd_ready_o, 1);
      step();
    end
    cmd_valid_i = 1'b0;
    chk("b2b_pending", pending_o, 4);
    chk("b2b_full", cmd_ready_o, 0);
    chk("b2b_issued_op", {cu_op_o, cu_src_o}, {6'h01, 32'h0});
    cmd_valid_i = 1'b1; cmd_op_i = OP_TRNG; cmd_src_i = 32'hDEAD;
    step();
    cmd_valid_i = 1'b0;
    step(); step();
    chk("b2b_no_bypass", pending_o, 4);
    chk("b2b_one_start", start_cnt - s0, 1);

    // Completion with simultaneous irq clear; next start two cycles later
    cu_done_i = 1'b1; irq_clr_i = 1'b1;
    step();
    cu_done_i = 1'b0; irq_clr_i = 1'b0;
    chk("irq_set_wins", irq_o, 1);
    chk("m1_start", cu_start_o, 0);
    chk("m1_done_cnt", done_cnt_o, 2);
    step();
    chk("m2_start", cu_start_o, 1);
    chk("m2_fields", {cu_op_o, cu_src_o}, {6'h02, 32'h10});
    chk("m2_pending", pending_o, 3);
    step();
    cu_done_i = 1'b1;
    step();
    cu_done_i = 1'b0;
    step();
    chk("m3_fields", {cu_start_o, cu_op_o, cu_src_o}, {1'b1, 6'h03, 32'h20});
    step();
    chk("m3_pending", pending_o, 2);

    // Reset while waiting with two queued
    s0 = start_cnt;
    rst_ni = 1'b0;
    #1;
    chk("rst_mid_pending", pending_o, 0);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_ready", cmd_ready_o, 1);
    chk("rst_mid_regs", {cu_start_o, cu_op_o, cu_src_o, irq_o, done_cnt_o}, 0);
    step();
    rst_ni = 1'b1;
    repeat (10) step();
    chk("rst_mid_nostart", start_cnt - s0, 0);
    chk("rst_mid_idle", {busy_o, pending_o}, 0);

    // 256 completions: counter wraps to zero
    timeouts = 0;
    op_mism = 0;
    for (int i = 0; i < 256; i++) begin
      cmd_valid_i = 1'b1; cmd_op_i = ops[i % 4]; cmd_src_i = 32'(i);
      step();
      cmd_valid_i = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
        step();
        if (cu_start_o) begin
          found = 1'b1;
          break;
        end
      end
      if (!found) timeouts++;
      if (cu_op_o !== ops[i % 4] || cu_src_o !== 32'(i)) op_mism++;
      step();
      cu_done_i = 1'b1;
      step();
      cu_done_i = 1'b0;
      if (i == 254) chk("wrap_255", done_cnt_o, 255);
    end
    chk("wrap_timeouts", timeouts, 0);
    chk("wrap_fields", op_mism, 0);
    chk("wrap_zero", done_cnt_o, 0);
    chk("wrap_irq", irq_o, 1);
    chk("wrap_idle", {busy_o, pending_o}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
